// File: rtl/add16_seq.sv
// Multi-word adder that reuses one 16-bit adder over WORDS cycles, LSW first,
// chaining the carry through a register between slices.

module add16 (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o,
    input  logic        ci_i,
    output logic        co_o
);
    assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {16'd0, ci_i};
endmodule

module add16_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [16*WORDS-1:0] a_in,
    input  logic [16*WORDS-1:0] b_in,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [16*WORDS-1:0] sum_out,
    output logic                cout,
    output logic                ovf
);
    localparam int W  = 16 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q, b_q, part_q, part_d, sum_q;
    logic          carry_q, cout_q, ovf_q;
    logic [15:0]   a_slice, b_slice, add_sum;
    logic          add_co;
    logic          accept, last;

    // A new request may be taken in IDLE or in the DONE cycle (back-to-back).
    assign accept = start && (state_q != S_BUSY);
    assign last   = (idx_q == IW'(WORDS - 1));

    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                a_slice = a_q[16*i +: 16];
                b_slice = b_q[16*i +: 16];
            end
        end
    end

    add16 u_add16 (
        .a_i   (a_slice),
        .b_i   (b_slice),
        .sum_o (add_sum),
        .ci_i  (carry_q),
        .co_o  (add_co)
    );

    // Partial result with the current slice merged in; on the last slice this is the full sum.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_part
            assign part_d[16*gi +: 16] = (idx_q == IW'(gi)) ? add_sum : part_q[16*gi +: 16];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = start ? S_BUSY : S_IDLE;
            S_BUSY:  state_d = last ? S_DONE : S_BUSY;
            S_DONE:  state_d = start ? S_BUSY : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_BUSY);
        done = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a_in;
            b_q     <= b_in;
            carry_q <= cin;
            idx_q   <= '0;
        end else if (state_q == S_BUSY) begin
            part_q  <= part_d;
            carry_q <= add_co;
            if (last) begin
                sum_q  <= part_d;
                cout_q <= add_co;
                ovf_q  <= (a_slice[15] == b_slice[15]) && (add_sum[15] != a_slice[15]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign sum_out = sum_q;
    assign cout    = cout_q;
    assign ovf     = ovf_q;
endmodule

// File: doc/add16_seq.md
# add16_seq

Multi-word adder sequencer that performs a (16·WORDS)-bit addition by time-multiplexing a single `add16` instance over WORDS clock cycles. It processes one 16-bit slice per cycle, least-significant word first, and chains the carry through a register. It sits between a requester using a start/done handshake and the shared 16-bit adder datapath, and replaces a wide combinational adder where area matters more than latency.

## Interface
- `WORDS`, default 4: number of 16-bit slices; legal range 1..8. Operand width W = 16·WORDS.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled on a rising edge only while the block is not busy.
- `a_in` input W: operand A; captured on the accepting edge.
- `b_in` input W: operand B; captured on the accepting edge.
- `cin` input 1: carry-in to word 0; captured on the accepting edge.
- `busy` output 1: high while slices are being processed.
- `done` output 1: one-cycle pulse; results are valid from this cycle onward.
- `sum_out` output W: result, A+B+cin mod 2^W.
- `cout` output 1: carry out of the MSW.
- `ovf` output 1: signed two's-complement overflow of the full W-bit add.

## Operation
- Exactly one `add16` instance is used, with port order (A, B, SUM, CI, CO). Slice idx feeds A=a_reg[16·idx+:16], B=b_reg[16·idx+:16], CI=carry_reg.
- States:
  - IDLE, BUSY, DONE.
  - Reset state is IDLE.
  - State encoding is free.
- IDLE:
  - start=1: capture a_in, b_in, cin into a_reg, b_reg, carry_reg; set idx=0; go to BUSY.
  - start=0: stay in IDLE.
- BUSY, on each edge:
  - part_reg[16·idx+:16] <= SUM, carry_reg <= CO.
  - If idx==WORDS-1: sum_out <= {SUM, lower part_reg}, cout <= CO, ovf <= (A[15]==B[15]) && (SUM[15]!=A[15]); go to DONE.
  - Otherwise idx <= idx+1.
  - start is ignored in BUSY. The operands are not re-captured.
- DONE:
  - done=1 for this single cycle.
  - start=1: accept a new request exactly as in IDLE and go to BUSY (back-to-back operation).
  - start=0: go to IDLE.
- sum_out, cout and ovf change only on the edge that enters DONE. They hold their values through IDLE and during any following BUSY period.
- Arithmetic is unsigned modulo 2^W. cout and ovf are independent flags.
- WORDS=1: BUSY lasts one cycle. The result equals a single add16 of the captured operands.
- Input changes on a_in, b_in or cin after the accepting edge have no effect.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, idx=0;
  - busy=0, done=0;
  - sum_out=0, cout=0, ovf=0;
  - all internal registers to 0.
- Reset mid-operation aborts the addition. No done pulse is produced. The first accept after rst_n rises is a fresh operation.
- start is accepted at edge E0, which must be in IDLE or DONE.
- busy is high for exactly WORDS cycles, covering edges E1..E_WORDS.
- done is high in the cycle following edge E_WORDS. Latency from accept to done is WORDS cycles.
- busy and done are never high together.
- Back-to-back requests sustain a throughput of one result per WORDS+1 cycles.
- All outputs are registered. There is no combinational path from an input to an output.

## Test plan
All scenarios use WORDS=4.
- Basic add: a=0x0000_0000_0001_3000, b=0x0000_0000_0000_5000, cin=0, start pulsed 1 cycle -> busy high 4 cycles, then done=1 for 1 cycle; sum_out=0x0000_0000_0001_8000, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0x0, cin=1 -> sum_out=0, cout=1, ovf=0. Carry propagates through all 4 slices.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum_out=0x8000_0000_0000_0000, cout=0, ovf=1. Then a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 -> sum_out=0, cout=1, ovf=1.
- Ignored and back-to-back starts:
  - start held high continuously with operands changed during BUSY -> the result reflects the operands captured at E0 only.
  - A new operation is accepted in the DONE cycle; the next done follows 5 cycles after the previous done.
- Reset mid-op: assert rst_n=0 asynchronously at the 2nd BUSY cycle -> all outputs 0 immediately and no done pulse. A fresh add 0x1+0x1 then yields sum_out=0x2.
- Randomised: 1000 random (a, b, cin) triples -> {cout, sum_out} equals a+b+cin, and ovf matches the signed reference model.
